// File: rtl/dmem_port_arbiter_if.sv
// Data-memory port bundle shared by the core MEM stage, an external master and dmem.
// The slave view belongs to the arbiter. The master view belongs to whatever drives
// the core/ext requests and models dmem.
interface dmem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // core MEM stage side
  logic          core_req;
  logic          core_we;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic [DW-1:0] core_rdata;
  logic          core_stall;

  // external master side (boot loader / debug)
  logic          ext_req;
  logic          ext_we;
  logic          ext_lock;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_wdata;
  logic          ext_ack;
  logic [DW-1:0] ext_rdata;

  // dmem side (combinational read)
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_rdata, core_stall,
    input  ext_req, ext_we, ext_lock, ext_addr, ext_wdata,
    output ext_ack, ext_rdata,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_rdata, core_stall,
    output ext_req, ext_we, ext_lock, ext_addr, ext_wdata,
    input  ext_ack, ext_rdata,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Two-owner arbiter for the single data-memory port. The core owns the port by
// default. The external master is granted when the core is idle, or after at most
// MAX_WAIT busy cycles. Locked external bursts are capped at BURST_MAX beats, and
// the core is stalled while the external master holds the port.
module dmem_port_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_WAIT  = 8,
  parameter int BURST_MAX = 16
) (
  input  logic               clk,
  input  logic               reset,
  dmem_port_arbiter_if.slave bus
);

  localparam int WCW = $clog2(MAX_WAIT + 1);
  localparam int BCW = $clog2(BURST_MAX + 1);

  localparam logic [WCW-1:0] WAIT_LAST = WCW'(MAX_WAIT - 1);
  localparam logic [WCW-1:0] WAIT_SAT  = WCW'(MAX_WAIT);
  localparam logic [BCW-1:0] BEAT_LAST = BCW'(BURST_MAX - 1);

  typedef enum logic {
    S_CORE = 1'b0,
    S_EXT  = 1'b1
  } state_t;

  state_t         state;
  logic [WCW-1:0] wait_cnt;
  logic [BCW-1:0] beat_cnt;

  logic           ext_sel;
  logic           ext_ack_int;
  logic           grant_ext;
  logic           release_ext;
  logic [AW-1:0]  addr_sel;
  logic [DW-1:0]  wdata_sel;
  logic           we_sel;

  // Port mux: ownership follows the registered state, so the selected master's
  // access reaches dmem in the same cycle. Reset forces every strobe low, which
  // also covers a reset arriving while the state is still S_EXT.
  always_comb begin
    ext_sel     = (state == S_EXT);
    addr_sel    = ext_sel ? bus.ext_addr  : bus.core_addr;
    wdata_sel   = ext_sel ? bus.ext_wdata : bus.core_wdata;
    we_sel      = ext_sel ? (bus.ext_we & bus.ext_req) : bus.core_we;
    ext_ack_int = ext_sel & bus.ext_req & ~reset;

    bus.mem_addr   = addr_sel;
    bus.mem_wdata  = wdata_sel;
    bus.mem_we     = we_sel & ~reset;
    bus.ext_ack    = ext_ack_int;
    bus.core_stall = ext_sel & bus.core_req & ~reset;
    bus.core_rdata = bus.mem_rdata;
    bus.ext_rdata  = bus.mem_rdata;
  end

  // Transition conditions: grant on an idle core or when the wait budget runs out.
  // Hand back on a dropped request, an unlocked beat, or the last beat of a capped
  // burst.
  always_comb begin
    grant_ext   = bus.ext_req & (~bus.core_req | (wait_cnt == WAIT_LAST));
    release_ext = ~bus.ext_req
                | (ext_ack_int & ~bus.ext_lock)
                | (ext_ack_int & (beat_cnt == BEAT_LAST));
  end

  // Ownership FSM with its wait and beat counters. Only control state is reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_CORE;
      wait_cnt <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        S_CORE: begin
          if (grant_ext) begin
            state    <= S_EXT;
            wait_cnt <= '0;
            beat_cnt <= '0;
          end else if (!bus.ext_req) begin
            wait_cnt <= '0;
          end else if (bus.core_req && (wait_cnt != WAIT_SAT)) begin
            wait_cnt <= wait_cnt + WCW'(1);
          end
        end
        S_EXT: begin
          if (!bus.ext_req) begin
            wait_cnt <= '0;
          end
          if (ext_ack_int && (beat_cnt != BCW'(BURST_MAX))) begin
            beat_cnt <= beat_cnt + BCW'(1);
          end
          if (release_ext) begin
            state <= S_CORE;
          end
        end
        default: begin
          state <= S_CORE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a behavioural dmem (combinational read,
// write on the rising edge).
module tb_dmem_port_arbiter;

  logic clk = 1'b0;
  logic reset;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mem [0:255] = '{default: 32'h0};

  dmem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

  dmem_port_arbiter #(
    .AW(32), .DW(32), .MAX_WAIT(8), .BURST_MAX(16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // behavioural dmem
  assign bus.mem_rdata = mem[bus.mem_addr[9:2]];
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] pat;
    logic [31:0] exp_pat;
    int          beat;
    int          cyc;
    int          bad;

    reset          = 1'b1;
    bus.core_req   = 1'b1;
    bus.core_we    = 1'b1;
    bus.core_addr  = 32'h40;
    bus.core_wdata = 32'h1111_1111;
    bus.ext_req    = 1'b0;
    bus.ext_we     = 1'b0;
    bus.ext_lock   = 1'b0;
    bus.ext_addr   = 32'h0;
    bus.ext_wdata  = 32'h0;

    // 1: reset held 3 cycles with a core store pending
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_mem_we", {31'h0, bus.mem_we}, 32'h0);
      check("rst_stall",  {31'h0, bus.core_stall}, 32'h0);
      check("rst_ack",    {31'h0, bus.ext_ack}, 32'h0);
    end
    tick();
    check("rst_no_write", mem[8'h10], 32'h0);

    // 2: core-only store then load
    reset          = 1'b0;
    bus.core_wdata = 32'hDEAD_BEEF;
    #1;
    check("core_st_we",    {31'h0, bus.mem_we}, 32'h1);
    check("core_st_stall", {31'h0, bus.core_stall}, 32'h0);
    check("core_st_addr",  bus.mem_addr, 32'h40);
    tick();
    bus.core_we = 1'b0;
    #1;
    check("core_ld_data", bus.core_rdata, 32'hDEAD_BEEF);

    // 3: external write with idle core
    tick();
    bus.core_req  = 1'b0;
    bus.ext_req   = 1'b1;
    bus.ext_we    = 1'b1;
    bus.ext_addr  = 32'h80;
    bus.ext_wdata = 32'h1234_5678;
    #1;
    check("ext_req_ack0", {31'h0, bus.ext_ack}, 32'h0);
    check("ext_req_we0",  {31'h0, bus.mem_we}, 32'h0);
    tick();
    check("ext_wr_ack", {31'h0, bus.ext_ack}, 32'h1);
    check("ext_wr_we",  {31'h0, bus.mem_we}, 32'h1);
    check("ext_wr_adr", bus.mem_addr, 32'h80);
    tick();
    bus.ext_req  = 1'b0;
    bus.ext_we   = 1'b0;
    bus.core_req = 1'b1;
    bus.core_addr = 32'h80;
    #1;
    check("ext_back_ack",  {31'h0, bus.ext_ack}, 32'h0);
    check("ext_back_data", bus.core_rdata, 32'h1234_5678);

    // 4: busy core, ext read waits MAX_WAIT cycles
    tick();
    bus.core_addr = 32'h40;
    bus.ext_req   = 1'b1;
    bus.ext_addr  = 32'h80;
    for (int k = 0; k < 8; k++) begin
      #1;
      check($sformatf("wait_ack_%0d", k),   {31'h0, bus.ext_ack}, 32'h0);
      check($sformatf("wait_stall_%0d", k), {31'h0, bus.core_stall}, 32'h0);
      tick();
    end
    check("wait_grant_ack",   {31'h0, bus.ext_ack}, 32'h1);
    check("wait_grant_stall", {31'h0, bus.core_stall}, 32'h1);
    check("wait_grant_rdata", bus.ext_rdata, 32'h1234_5678);
    check("wait_grant_we",    {31'h0, bus.mem_we}, 32'h0);
    tick();
    bus.ext_req = 1'b0;
    #1;
    check("wait_after_stall", {31'h0, bus.core_stall}, 32'h0);
    check("wait_after_ack",   {31'h0, bus.ext_ack}, 32'h0);

    // 5: locked burst of 20 writes with BURST_MAX=16
    tick();
    bus.core_req = 1'b0;
    bus.core_we  = 1'b0;
    pat  = '0;
    beat = 0;
    cyc  = 0;
    while (beat < 20 && cyc < 32) begin
      bus.ext_req   = 1'b1;
      bus.ext_we    = 1'b1;
      bus.ext_lock  = (beat != 19);
      bus.ext_addr  = 32'h100 + 32'(beat) * 4;
      bus.ext_wdata = 32'hA500_0000 + 32'(beat);
      #1;
      pat[cyc] = bus.ext_ack;
      if (bus.ext_ack) beat++;
      cyc++;
      tick();
    end
    bus.ext_req  = 1'b0;
    bus.ext_we   = 1'b0;
    bus.ext_lock = 1'b0;
    exp_pat = '0;
    for (int i = 1; i <= 16; i++) exp_pat[i] = 1'b1;
    for (int i = 18; i <= 21; i++) exp_pat[i] = 1'b1;
    check("burst_cycles", 32'(cyc), 32'd22);
    check("burst_ack_pattern", pat, exp_pat);
    bad = 0;
    for (int i = 0; i < 20; i++)
      if (mem[8'h40 + i] !== 32'hA500_0000 + 32'(i)) bad++;
    check("burst_mem_bad", 32'(bad), 32'd0);
    bus.core_req  = 1'b1;
    bus.core_addr = 32'h14C;
    #1;
    check("burst_core_ld", bus.core_rdata, 32'hA500_0013);

    // 6: reset mid-burst at beat 5
    tick();
    bus.core_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.ext_req   = 1'b1;
      bus.ext_we    = 1'b1;
      bus.ext_lock  = 1'b1;
      bus.ext_addr  = 32'h180 + 32'(i > 0 ? i - 1 : 0) * 4;
      bus.ext_wdata = 32'h5A00_0000 + 32'(i > 0 ? i - 1 : 0);
      #1;
      check($sformatf("rb_ack_%0d", i), {31'h0, bus.ext_ack}, (i == 0) ? 32'h0 : 32'h1);
      tick();
    end
    reset          = 1'b1;
    bus.core_req   = 1'b1;
    bus.core_we    = 1'b1;
    bus.core_addr  = 32'h1FC;
    bus.ext_addr   = 32'h194;
    bus.ext_wdata  = 32'h0000_0BAD;
    #1;
    check("rb_rst_ack",   {31'h0, bus.ext_ack}, 32'h0);
    check("rb_rst_we",    {31'h0, bus.mem_we}, 32'h0);
    check("rb_rst_stall", {31'h0, bus.core_stall}, 32'h0);
    tick();
    check("rb_no_write", mem[8'h65], 32'h0);
    bad = 0;
    for (int i = 0; i < 5; i++)
      if (mem[8'h60 + i] !== 32'h5A00_0000 + 32'(i)) bad++;
    check("rb_beats_bad", 32'(bad), 32'd0);
    reset         = 1'b0;
    bus.core_req  = 1'b0;
    bus.core_we   = 1'b0;
    bus.ext_lock  = 1'b0;
    bus.ext_addr  = 32'h200;
    bus.ext_wdata = 32'hC0FF_EE00;
    #1;
    check("rb_post_ack0", {31'h0, bus.ext_ack}, 32'h0);
    tick();
    check("rb_post_ack1", {31'h0, bus.ext_ack}, 32'h1);
    check("rb_post_we",   {31'h0, bus.mem_we}, 32'h1);
    tick();
    bus.ext_req = 1'b0;
    bus.ext_we  = 1'b0;
    #1;
    check("rb_post_ack_end", {31'h0, bus.ext_ack}, 32'h0);
    check("rb_post_mem",     mem[8'h80], 32'hC0FF_EE00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
